// File: rtl/ps2_frame_ctrl.sv
// PS/2 frame receiver: assembles start/8 data/parity/stop from edge strobes, validates, and
// strobes out the scan code. Optional parity checking is enabled by defining PARITY_CHECK_EN.
module ps2_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edge_found,
  input  logic       kb_data_sync,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [7:0]       scan_code_q, scan_code_d;
  logic             scan_valid_q, scan_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             parity_ok;
  logic             timeout;

`ifdef PARITY_CHECK_EN
  logic parity_q, parity_d;
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Expires on the cycle the count would reach TIMEOUT_CYCLES; an edge that cycle wins.
  assign timeout = (state_q != StIdle) && !edge_found &&
                   (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_d     = parity_q;
`endif

    if (state_q == StIdle || edge_found) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + CNT_W'(1);
    end

    if (timeout) begin
      state_d     = StIdle;
      bit_cnt_d   = 3'd0;
      frame_err_d = 1'b1;
      wdog_d      = '0;
    end else if (edge_found) begin
      unique case (state_q)
        StIdle: begin
          if (!kb_data_sync) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {kb_data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
`ifdef PARITY_CHECK_EN
          parity_d = kb_data_sync;
`endif
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (kb_data_sync && parity_ok) begin
            scan_code_d  = shift_q;
            scan_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      wdog_q       <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wdog_q       <= wdog_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef PARITY_CHECK_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// Randomized bench for ps2_frame_ctrl: a bit-queue frame model predicts every output each cycle,
// and a few directed frames pin literal results.
module tb_ps2_frame_ctrl;

  localparam int unsigned TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       edge_found = 1'b0;
  logic       kb_data_sync = 1'b0;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic       busy;

  ps2_frame_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .edge_found   (edge_found),
    .kb_data_sync (kb_data_sync),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: bits of the frame collected so far, and cycles since last edge.
  bit         m_bits[$];
  int         m_idle = 0;
  logic [7:0] m_code = 8'h00;
  logic [7:0] exp_code = 8'h00, nxt_code;
  logic       exp_valid = 1'b0, nxt_valid;
  logic       exp_err = 1'b0, nxt_err;
  logic       exp_busy = 1'b0, nxt_busy;
  bit         check_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit d);
    int         ones;
    logic [7:0] c;
    bit         good;
    nxt_valid = 1'b0;
    nxt_err   = 1'b0;
    if (r) begin
      m_bits.delete();
      m_idle = 0;
      m_code = 8'h00;
    end else if (e) begin
      m_idle = 0;
      if (m_bits.size() != 0 || d == 1'b0) m_bits.push_back(d);
      if (m_bits.size() == 11) begin
        ones = 0;
        c    = 8'h00;
        for (int i = 0; i < 8; i++) c[i] = m_bits[i + 1];
        for (int i = 1; i <= 9; i++) ones += int'(m_bits[i]);
`ifdef PARITY_CHECK_EN
        good = m_bits[10] && (ones % 2 == 1);
`else
        good = m_bits[10];
`endif
        if (good) begin
          m_code    = c;
          nxt_valid = 1'b1;
        end else begin
          nxt_err = 1'b1;
        end
        m_bits.delete();
      end
    end else if (m_bits.size() != 0) begin
      m_idle++;
      if (m_idle >= int'(TO)) begin
        nxt_err = 1'b1;
        m_bits.delete();
        m_idle = 0;
      end
    end
    nxt_busy = (m_bits.size() != 0);
    nxt_code = m_code;
  endtask

  // One clock: drive inputs, advance the model, publish expectations just after the edge.
  task automatic tick(input bit r, input bit e, input bit d);
    rst          = r;
    edge_found   = e;
    kb_data_sync = d;
    model_step(r, e, d);
    @(posedge clk);
    #1;
    exp_code  = nxt_code;
    exp_valid = nxt_valid;
    exp_err   = nxt_err;
    exp_busy  = nxt_busy;
    check_en  = 1'b1;
  endtask

  task automatic idle_n(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'($urandom % 2));
  endtask

  // Sends the first nbits of a frame; no trailing gap after the last bit.
  task automatic send_frame(input logic [7:0] code, input bit pflip, input bit stop,
                            input int nbits, input int gmin, input int gmax);
    bit b[11];
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i + 1] = code[i];
    b[9]  = ~(^code) ^ pflip;
    b[10] = stop;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) idle_n(int'($urandom_range(gmax, gmin)));
      tick(1'b0, 1'b1, b[i]);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("scan_code", scan_code, exp_code);
      chk("scan_valid", 8'(scan_valid), 8'(exp_valid));
      chk("frame_err", 8'(frame_err), 8'(exp_err));
      chk("busy", 8'(busy), 8'(exp_busy));
      if (scan_valid && frame_err) begin
        n_vec++;
        n_bad++;
        $display("FAIL strobe_excl: scan_valid=1 frame_err=1 at %0t", $time);
      end
    end
  end

  initial begin
    int r;
    int nb;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    chk("reset_code", scan_code, 8'h00);
    chk("reset_busy", 8'(busy), 8'h00);

    // Frame 0x1C, good parity.
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1, 3);
    chk("t1_valid", 8'(scan_valid), 8'h01);
    chk("t1_code", scan_code, 8'h1C);
    idle_n(2);

    // Frame 0x1C with wrong parity.
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1, 3);
`ifdef PARITY_CHECK_EN
    chk("t2_err", 8'(frame_err), 8'h01);
    chk("t2_valid", 8'(scan_valid), 8'h00);
`else
    chk("t2_valid", 8'(scan_valid), 8'h01);
`endif
    chk("t2_code", scan_code, 8'h1C);
    idle_n(2);

    // Frame 0xF0, bad stop bit.
    send_frame(8'hF0, 1'b0, 1'b0, 11, 1, 3);
    chk("t3_err", 8'(frame_err), 8'h01);
    chk("t3_valid", 8'(scan_valid), 8'h00);
    idle_n(1);
    chk("t3_busy", 8'(busy), 8'h00);

    // Stall mid-frame for the full timeout.
    send_frame(8'h55, 1'b0, 1'b1, 4, 1, 2);
    idle_n(int'(TO) - 1);
    chk("t4_busy_before", 8'(busy), 8'h01);
    idle_n(1);
    chk("t4_err", 8'(frame_err), 8'h01);
    chk("t4_busy", 8'(busy), 8'h00);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1, 3);
    chk("t4_valid", 8'(scan_valid), 8'h01);
    chk("t4_code", scan_code, 8'hF0);
    idle_n(2);

    // Every gap one cycle short of expiry: edges must keep the frame alive.
    send_frame(8'hA7, 1'b0, 1'b1, 11, int'(TO) - 1, int'(TO) - 1);
    chk("wd_edge_valid", 8'(scan_valid), 8'h01);
    chk("wd_edge_code", scan_code, 8'hA7);
    idle_n(2);

    // Reset after 5 edges.
    send_frame(8'h3C, 1'b0, 1'b1, 5, 1, 2);
    tick(1'b1, 1'b0, 1'b0);
    chk("t5_busy", 8'(busy), 8'h00);
    chk("t5_code", scan_code, 8'h00);
    chk("t5_valid", 8'(scan_valid), 8'h00);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1, 3);
    chk("t5_code2", scan_code, 8'h1C);
    idle_n(2);

    // Idle glitch: edge with data high.
    tick(1'b0, 1'b1, 1'b1);
    chk("t6_busy", 8'(busy), 8'h00);
    chk("t6_err", 8'(frame_err), 8'h00);
    idle_n(2);

    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(99, 0));
      if (r < 8) begin
        tick(1'b0, 1'b1, 1'b1);
      end else if (r < 13) begin
        nb = int'($urandom_range(10, 1));
        send_frame(8'($urandom), 1'($urandom), 1'($urandom), nb, 1, 4);
        tick(1'b1, 1'b0, 1'b0);
      end else if (r < 20) begin
        nb = int'($urandom_range(10, 1));
        send_frame(8'($urandom), 1'b0, 1'b1, nb, 1, 4);
        idle_n(int'(TO) + int'($urandom_range(2, 0)) - 1);
      end else if (r < 23) begin
        send_frame(8'($urandom), 1'($urandom_range(9, 0) == 0), 1'b1, 11,
                   int'(TO) - 2, int'(TO));
      end else begin
        send_frame(8'($urandom), 1'($urandom_range(9, 0) == 0),
                   1'($urandom_range(9, 0) != 0), 11, 1, 5);
      end
      idle_n(int'($urandom_range(4, 1)));
    end

    idle_n(2);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
